// File: rtl/nfc_pkg.sv
// Shared types and constants for the NAND host sequencer.
package nfc_pkg;

  localparam int PAGE_BYTES = 2048;

  typedef enum logic [2:0] {
    OP_PROG  = 3'b001,
    OP_READ  = 3'b010,
    OP_RESET = 3'b011,
    OP_ERASE = 3'b100,
    OP_RDID  = 3'b101
  } nfc_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } nfc_state_e;

  // rsp_status = {timeout, op_err, illegal}
  localparam int STS_TIMEOUT = 2;
  localparam int STS_OPERR   = 1;
  localparam int STS_ILLEGAL = 0;

endpackage

// File: rtl/nfc_rd_skid.sv
// Output register plus one skid entry; absorbs the byte still in flight
// from the buffer when the consumer stalls.
module nfc_rd_skid (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       busy
);

  logic       sk_valid;
  logic [7:0] sk_data;
  logic       take;

  assign take = !out_valid || out_ready;
  assign busy = sk_valid || (out_valid && !out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
    end else if (take) begin
      if (sk_valid) begin
        // older byte in the skid always goes out first
        out_valid <= 1'b1;
        out_data  <= sk_data;
        sk_valid  <= in_valid;
        if (in_valid) sk_data <= in_data;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid) begin
      sk_valid <= 1'b1;
      sk_data  <= in_data;
    end
  end

endmodule

// File: rtl/nfc_host_seq.sv
// Host-side command sequencer: fills the page buffer, kicks the NAND
// controller, waits for completion and drains read data.
module nfc_host_seq #(
  parameter int PAGE_BYTES  = nfc_pkg::PAGE_BYTES,
  parameter int ID_BYTES    = 5,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [7:0]  rd_data,
  output logic        rsp_valid,
  output logic [2:0]  rsp_status,
  output logic        BF_Sel,
  output logic        BF_we,
  output logic [10:0] BF_ad,
  output logic [7:0]  BF_din,
  input  logic [7:0]  BF_dou,
  output logic [2:0]  nfc_cmd,
  output logic        nfc_strt,
  input  logic        nfc_done,
  output logic [15:0] RWA,
  input  logic        Perr,
  input  logic        EErr,
  input  logic        RErr
);
  import nfc_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  nfc_state_e    state;
  logic [2:0]    op;
  logic [15:0]   addr;
  logic [10:0]   cnt;
  logic [TW-1:0] tcnt;
  logic          fetch_done;
  logic          inflight;
  logic [10:0]   last_idx;
  logic          beat;
  logic          fetch;
  logic          skid_busy;
  logic          drain_end;
  logic          op_err;

  assign beat      = (state == S_FILL) && wr_valid;
  // fetching only while the consumer is ready keeps BF_ad frozen on a stall
  assign fetch     = (state == S_DRAIN) && rd_ready && !fetch_done;
  assign last_idx  = (op == OP_READ) ? 11'(PAGE_BYTES - 1) : 11'(ID_BYTES - 1);
  assign drain_end = fetch_done && !inflight && !skid_busy;
  assign op_err    = (op == OP_PROG  && Perr) ||
                     (op == OP_ERASE && EErr) ||
                     (op == OP_READ  && RErr);

  assign wr_ready = (state == S_FILL);
  assign BF_Sel   = (state == S_FILL) || (state == S_DRAIN);
  assign BF_we    = beat;
  assign BF_din   = beat ? wr_data : 8'h00;
  assign BF_ad    = BF_Sel ? cnt : 11'h000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      op         <= '0;
      addr       <= '0;
      cnt        <= '0;
      tcnt       <= '0;
      fetch_done <= 1'b0;
      inflight   <= 1'b0;
      nfc_strt   <= 1'b0;
      nfc_cmd    <= '0;
      RWA        <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
    end else begin
      inflight <= fetch;
      case (state)
        S_IDLE: if (req_valid && req_ready) begin
          op         <= req_op;
          addr       <= req_addr;
          req_ready  <= 1'b0;
          cnt        <= '0;
          tcnt       <= '0;
          fetch_done <= 1'b0;
          rsp_status <= '0;
          case (req_op)
            OP_PROG: state <= S_FILL;
            OP_READ, OP_ERASE, OP_RESET, OP_RDID: begin
              state    <= S_ISSUE;
              nfc_strt <= 1'b1;
              nfc_cmd  <= req_op;
              RWA      <= req_addr;
            end
            default: begin
              state                   <= S_RESP;
              rsp_valid               <= 1'b1;
              rsp_status[STS_ILLEGAL] <= 1'b1;
            end
          endcase
        end
        S_FILL: if (beat) begin
          if (cnt == 11'(PAGE_BYTES - 1)) begin
            cnt      <= '0;
            state    <= S_ISSUE;
            nfc_strt <= 1'b1;
            nfc_cmd  <= op;
            RWA      <= addr;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        S_ISSUE: begin
          nfc_strt <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (nfc_done) begin
            rsp_status[STS_OPERR] <= op_err;
            if (op == OP_READ || op == OP_RDID) begin
              state <= S_DRAIN;
            end else begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            rsp_status[STS_TIMEOUT] <= 1'b1;
            state                   <= S_RESP;
            rsp_valid               <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (fetch) begin
            if (cnt == last_idx) fetch_done <= 1'b1;
            else                 cnt        <= cnt + 11'd1;
          end
          if (drain_end) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          rsp_valid  <= 1'b0;
          rsp_status <= '0;
          req_ready  <= 1'b1;
          nfc_cmd    <= '0;
          RWA        <= '0;
          cnt        <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  nfc_rd_skid u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_valid (inflight),
    .in_data  (BF_dou),
    .out_ready(rd_ready),
    .out_valid(rd_valid),
    .out_data (rd_data),
    .busy     (skid_busy)
  );

endmodule
